plot_sweep_sequencer: RTL and testbench
=======================================

PLOT_SWEEP_SEQUENCER -- requirements
Module: plot_sweep_sequencer

Interface
REQ-001 Parameter: XW, default 8, width of the x-coordinate path.
REQ-002 Parameter: OVW, default 8, width of the overrun counter.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low; sampled on clk rising edge only.
REQ-005 Port: enable  input  1  high = sweep may advance; low = freeze.
REQ-006 Port: tick  input  1  one-cycle pulse, high when the upstream rate-divider count equals zero.
REQ-007 Port: start  input  1  one-cycle request to begin a sweep.
REQ-008 Port: x_min  input  XW  first x of the sweep, unsigned.
REQ-009 Port: x_max  input  XW  last x of the sweep, unsigned, inclusive.
REQ-010 Port: x_ready  input  1  downstream evaluator accepts x_out this cycle.
REQ-011 Port: x_out  output  XW  current x coordinate offered downstream.
REQ-012 Port: x_valid  output  1  x_out is valid; transfer when x_valid and x_ready are both high.
REQ-013 Port: busy  output  1  high in any state other than IDLE.
REQ-014 Port: done  output  1  one-cycle pulse after the last x has been transferred.
REQ-015 Port: range_err  output  1  sticky; set when start is accepted with x_min > x_max.
REQ-016 Port: overrun  output  OVW  saturating count of dropped ticks.

Function
REQ-017 States SHALL be IDLE, WAIT_TICK, ISSUE, and FINISH.
REQ-018 IDLE: on start=1, latch x_min and x_max, set x_out=x_min, and clear overrun and range_err.
REQ-019 IDLE: if latched x_min <= x_max, go to WAIT_TICK; otherwise set range_err and go to FINISH.
REQ-020 IDLE: ignore tick, and do not count it as overrun.
REQ-021 WAIT_TICK: when enable=1 and (tick=1 or the pending flag is set), clear pending and go to ISSUE next cycle.
REQ-022 ISSUE: x_valid=1; x_out SHALL hold stable until the transfer completes.
REQ-023 ISSUE: once x_valid is raised, it SHALL NOT drop before the transfer, regardless of enable.
REQ-024 ISSUE on transfer with x_out == x_max: go to FINISH.
REQ-025 ISSUE on transfer with x_out < x_max: set x_out <= x_out+1 and go to WAIT_TICK.
REQ-026 x_out increment SHALL NOT wrap; x_max = 2^XW-1 terminates via REQ-024 before any increment.
REQ-027 FINISH: done=1 for exactly one cycle, then go to IDLE; busy=1 during FINISH.
REQ-028 Pending flag is one-deep: a tick arriving in ISSUE with pending=0 sets pending.
REQ-029 A tick arriving in ISSUE with pending=1 increments overrun, saturating at 2^OVW-1.
REQ-030 A tick arriving in WAIT_TICK while enable=0 increments overrun and is otherwise dropped.
REQ-031 A tick in the same cycle as the ISSUE transfer SHALL set pending; it is not an overrun.
REQ-032 start while busy=1 SHALL be ignored, with no change to latched limits or x_out.
REQ-033 Latched x_min and x_max SHALL NOT follow input changes during a sweep.
REQ-034 x_min == x_max SHALL produce exactly one transfer, then done.
REQ-035 Latency: tick seen in WAIT_TICK -> x_valid high on the next cycle; transfer -> done on the next cycle when last.

Reset
REQ-036 When reset=0 at a clk edge: state=IDLE, x_out=0, x_valid=0, busy=0, done=0, range_err=0, overrun=0, pending=0, latched limits=0.
REQ-037 Reset mid-sweep SHALL abort immediately; no done pulse; the following start begins a fresh sweep.
REQ-038 reset SHALL take priority over start, tick and x_ready in the same cycle.

Verification
REQ-039 Scenario: x_min=3, x_max=6, x_ready=1, tick every 4 cycles -> x_out transfers 3,4,5,6 in order, one per tick, then one done pulse.
REQ-040 Scenario: x_min=5, x_max=5 -> exactly one transfer of 5 and one done; x_min=9, x_max=2 -> range_err=1, done pulse, zero transfers.
REQ-041 Scenario: x_ready=0 held for 10 cycles while 3 ticks arrive -> x_valid stays high and x_out stable, pending=1, overrun=2; then x_ready=1 -> next x issued on the following cycle.
REQ-042 Scenario: x_max=255 with XW=8 -> last transfer is 255, done follows, no transfer of 0.
REQ-043 Scenario: reset=0 asserted during ISSUE -> next cycle all outputs are 0 and no done pulse; start then restarts from the new x_min.
REQ-044 Scenario: start pulsed mid-sweep with different limits -> sweep continues unchanged to the original x_max.

Source files
------------

// File: rtl/plot_sweep_sequencer.sv
// plot_sweep_sequencer
// Walks an x coordinate from a latched x_min to a latched x_max (inclusive).
// Each x is offered downstream once per upstream tick. A one-deep pending flag
// absorbs a single early tick. Further early ticks, and ticks that arrive while
// frozen, are counted in a saturating overrun counter.
//
// Handshake: x_out is offered while x_valid is high. A transfer happens in any
// cycle where x_valid and x_ready are both high. Once x_valid is raised, it
// stays high and x_out stays stable until that transfer, whatever enable does.
module plot_sweep_sequencer #(
  parameter int XW  = 8,
  parameter int OVW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           tick,
  input  logic           start,
  input  logic [XW-1:0]  x_min,
  input  logic [XW-1:0]  x_max,
  input  logic           x_ready,
  output logic [XW-1:0]  x_out,
  output logic           x_valid,
  output logic           busy,
  output logic           done,
  output logic           range_err,
  output logic [OVW-1:0] overrun,
  output logic [1:0]     dbg_state,
  output logic           dbg_pending
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    ISSUE     = 2'd2,
    FINISH    = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  // x_min is latched straight into r_x, which is the running coordinate.
  // Only the upper limit needs a separate register.
  logic [XW-1:0]  r_x;
  logic [XW-1:0]  r_hi;
  logic [OVW-1:0] r_overrun;
  logic           r_range_err;
  logic           r_pending;

  logic           w_start_ok;
  logic           w_range_bad;
  logic           w_take;
  logic           w_xfer;
  logic           w_last;
  logic           w_ovr_hit;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = (r_state == IDLE) && start;
    w_range_bad = (x_min > x_max);
    w_take      = (r_state == WAIT_TICK) && enable && (tick || r_pending);
    w_xfer      = (r_state == ISSUE) && x_ready;
    w_last      = (r_x == r_hi);
    // An overrun is a tick dropped while frozen in WAIT_TICK, or a tick that
    // arrives during ISSUE when the pending slot is already full. A tick that
    // coincides with the transfer refills pending and is not an overrun.
    w_ovr_hit   = ((r_state == WAIT_TICK) && tick && !enable) ||
                  ((r_state == ISSUE) && tick && r_pending && !w_xfer);
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = w_range_bad ? FINISH : WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (w_take) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (w_xfer) begin
          w_state_nxt = w_last ? FINISH : WAIT_TICK;
        end
      end
      FINISH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: latched limits, coordinate, pending flag, error and overrun
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x         <= '0;
      r_hi        <= '0;
      r_overrun   <= '0;
      r_range_err <= 1'b0;
      r_pending   <= 1'b0;
    end else if (w_start_ok) begin
      // Pending is cleared here as well, so that a stale tick from the
      // previous sweep cannot issue the first x early.
      r_x         <= x_min;
      r_hi        <= x_max;
      r_overrun   <= '0;
      r_range_err <= w_range_bad;
      r_pending   <= 1'b0;
    end else begin
      if (w_ovr_hit && (r_overrun != '1)) begin
        r_overrun <= r_overrun + OVW'(1);
      end
      if (w_take) begin
        r_pending <= 1'b0;
      end else if ((r_state == ISSUE) && tick) begin
        r_pending <= 1'b1;
      end
      // The last x leaves r_x untouched, so x_max = all-ones never wraps.
      if (w_xfer && !w_last) begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  assign x_out       = r_x;
  assign x_valid     = (r_state == ISSUE);
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == FINISH);
  assign range_err   = r_range_err;
  assign overrun     = r_overrun;
  assign dbg_state   = r_state;
  assign dbg_pending = r_pending;

endmodule

// File: tb/tb_plot_sweep_sequencer.sv
// Bench for plot_sweep_sequencer: a vector table, hand-written corner
// sequences, and randomized traffic. Every cycle is compared against a
// behavioural sweep model. A scoreboard queue holds the expected transfer order.
module tb_plot_sweep_sequencer;

  localparam int XW  = 8;
  localparam int OVW = 8;

  // ---------------- clock / reset block ----------------
  logic clk;
  logic reset, enable, tick, start, x_ready;
  logic [XW-1:0] x_min, x_max;
  logic [XW-1:0] x_out;
  logic x_valid, busy, done, range_err;
  logic [OVW-1:0] overrun;
  logic [1:0] dbg_state;
  logic dbg_pending;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  plot_sweep_sequencer #(.XW(XW), .OVW(OVW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tick(tick), .start(start),
    .x_min(x_min), .x_max(x_max), .x_ready(x_ready),
    .x_out(x_out), .x_valid(x_valid), .busy(busy), .done(done),
    .range_err(range_err), .overrun(overrun),
    .dbg_state(dbg_state), .dbg_pending(dbg_pending)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_xfer   = 0;
  logic [XW-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The sweep is described by three facts: whether a sweep is in progress,
  // whether an x is currently being offered, and whether the completion pulse
  // is due.
  logic m_busy, m_offer, m_done, m_pend, m_err;
  logic [XW-1:0] m_x, m_hi;
  int m_ovr;

  task automatic model_step(input logic r, input logic en, input logic tk,
                            input logic st, input logic [XW-1:0] mn,
                            input logic [XW-1:0] mx, input logic rd);
    logic xf;
    if (!r) begin
      m_busy = 0; m_offer = 0; m_done = 0; m_pend = 0; m_err = 0;
      m_x = 0; m_hi = 0; m_ovr = 0;
      return;
    end
    xf = m_offer && rd;
    if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (st) begin
        m_x = mn; m_hi = mx; m_ovr = 0; m_err = 0; m_pend = 0; m_busy = 1;
        if (mn > mx) begin
          m_err = 1;
          m_done = 1;
        end
      end
    end else if (!m_offer) begin
      if (tk && !en) begin
        if (m_ovr < (1 << OVW) - 1) m_ovr++;
      end else if (en && (tk || m_pend)) begin
        m_pend = 0;
        m_offer = 1;
      end
    end else begin
      if (tk) begin
        if (xf || !m_pend) m_pend = 1;
        else if (m_ovr < (1 << OVW) - 1) m_ovr++;
      end
      if (xf) begin
        exp_q.push_back(m_x);
        m_offer = 0;
        if (m_x == m_hi) m_done = 1;
        else m_x = m_x + 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive the inputs on the falling edge, observe the
  // transfer, advance the model, then compare the outputs 1 ns after the rising edge.
  task automatic cyc(input logic r, input logic en, input logic tk,
                     input logic st, input logic [XW-1:0] mn,
                     input logic [XW-1:0] mx, input logic rd);
    logic d_xf;
    logic [XW-1:0] d_x, e_x;
    @(negedge clk);
    reset = r; enable = en; tick = tk; start = st;
    x_min = mn; x_max = mx; x_ready = rd;
    #1;
    d_xf = x_valid && x_ready && reset;
    d_x  = x_out;
    model_step(r, en, tk, st, mn, mx, rd);
    @(posedge clk);
    #1;
    if (d_xf) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        check("unexpected_transfer", int'(d_x), -1);
      end else begin
        e_x = exp_q.pop_front();
        check("transfer_x", int'(d_x), int'(e_x));
      end
    end
    check("x_out",     int'(x_out),     int'(m_x));
    check("x_valid",   int'(x_valid),   int'(m_offer));
    check("busy",      int'(busy),      int'(m_busy));
    check("done",      int'(done),      int'(m_done));
    check("range_err", int'(range_err), int'(m_err));
    check("overrun",   int'(overrun),   m_ovr);
    check("pending",   int'(dbg_pending), int'(m_pend));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst, en, tk, st;
    logic [XW-1:0] mn, mx;
    logic rd;
    logic [XW-1:0] e_x;
    logic e_v, e_b, e_d, e_err;
    logic [OVW-1:0] e_ovr;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int base;
    reset = 0; enable = 0; tick = 0; start = 0; x_min = 0; x_max = 0; x_ready = 0;

    //          rst en tk st  mn mx rd   x  v  b  d  e  ovr
    tbl[0]  = '{0, 1, 0, 0,  3, 6, 1,   0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 1,  3, 6, 1,   3, 0, 1, 0, 0, 0};
    tbl[2]  = '{1, 1, 1, 0,  3, 6, 1,   3, 1, 1, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0,  3, 6, 0,   3, 1, 1, 0, 0, 0};
    tbl[4]  = '{1, 1, 1, 0,  3, 6, 0,   3, 1, 1, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 0,  3, 6, 0,   3, 1, 1, 0, 0, 1};
    tbl[6]  = '{1, 1, 0, 0,  3, 6, 1,   4, 0, 1, 0, 0, 1};
    tbl[7]  = '{1, 1, 0, 0,  3, 6, 1,   4, 1, 1, 0, 0, 1};
    tbl[8]  = '{1, 1, 0, 1,  0, 0, 1,   5, 0, 1, 0, 0, 1};
    tbl[9]  = '{1, 0, 1, 0,  0, 0, 1,   5, 0, 1, 0, 0, 2};
    tbl[10] = '{1, 1, 1, 0,  0, 0, 1,   5, 1, 1, 0, 0, 2};
    tbl[11] = '{1, 1, 0, 0,  0, 0, 1,   6, 0, 1, 0, 0, 2};
    tbl[12] = '{1, 1, 1, 0,  0, 0, 1,   6, 1, 1, 0, 0, 2};
    tbl[13] = '{1, 1, 0, 0,  0, 0, 1,   6, 0, 1, 1, 0, 2};
    tbl[14] = '{1, 1, 0, 0,  0, 0, 1,   6, 0, 0, 0, 0, 2};
    tbl[15] = '{1, 1, 0, 1,  9, 2, 1,   9, 0, 1, 1, 1, 0};
    tbl[16] = '{1, 1, 0, 0,  9, 2, 1,   9, 0, 0, 0, 1, 0};

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].tk, tbl[i].st, tbl[i].mn, tbl[i].mx, tbl[i].rd);
      check($sformatf("tbl%0d_x", i),     int'(x_out),     int'(tbl[i].e_x));
      check($sformatf("tbl%0d_valid", i), int'(x_valid),   int'(tbl[i].e_v));
      check($sformatf("tbl%0d_busy", i),  int'(busy),      int'(tbl[i].e_b));
      check($sformatf("tbl%0d_done", i),  int'(done),      int'(tbl[i].e_d));
      check($sformatf("tbl%0d_err", i),   int'(range_err), int'(tbl[i].e_err));
      check($sformatf("tbl%0d_ovr", i),   int'(overrun),   int'(tbl[i].e_ovr));
    end
    check("tbl_transfers", n_xfer, 4);

    // Single-point sweep 5..5: one transfer, then done.
    base = n_xfer;
    cyc(1, 1, 0, 1, 5, 5, 1);
    cyc(1, 1, 1, 0, 5, 5, 1);
    cyc(1, 1, 0, 0, 5, 5, 1);
    check("single_done", int'(done), 1);
    cyc(1, 1, 0, 0, 5, 5, 1);
    check("single_count", n_xfer - base, 1);

    // Top of range: 254..255 must end at 255 without wrapping to 0.
    base = n_xfer;
    cyc(1, 1, 0, 1, 254, 255, 1);
    cyc(1, 1, 1, 0, 254, 255, 1);
    cyc(1, 1, 0, 0, 254, 255, 1);
    cyc(1, 1, 1, 0, 254, 255, 1);
    cyc(1, 1, 0, 0, 254, 255, 1);
    check("top_done", int'(done), 1);
    check("top_x", int'(x_out), 255);
    cyc(1, 1, 0, 0, 254, 255, 1);
    cyc(1, 1, 1, 0, 254, 255, 1);
    check("top_count", n_xfer - base, 2);

    // Reset during ISSUE wins over start, tick and ready, and gives no done.
    cyc(1, 1, 0, 1, 10, 20, 0);
    cyc(1, 1, 1, 0, 10, 20, 0);
    check("rst_in_issue", int'(x_valid), 1);
    cyc(0, 1, 1, 1, 30, 40, 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(x_out), 0);
    cyc(1, 1, 0, 0, 30, 40, 1);
    check("rst_no_done", int'(done), 0);
    cyc(1, 1, 0, 1, 40, 41, 1);
    check("restart_x", int'(x_out), 40);
    cyc(0, 1, 0, 0, 0, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic r, en, tk, st, rd;
      logic [XW-1:0] mn, mx;
      int span;
      r  = ($urandom_range(0, 199) != 0);
      en = ($urandom_range(0, 9) != 0);
      tk = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 2) != 0);
      mn = XW'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) begin
        mx = XW'($urandom_range(0, 255));
      end else begin
        span = int'(mn) + $urandom_range(0, 5);
        mx = (span > 255) ? 8'd255 : XW'(span);
      end
      cyc(r, en, tk, st, mn, mx, rd);
    end
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
